// File: rtl/r4_booth_seq_ctrl.sv
// ---------------------------------------------------------------------------
// r4_booth_seq_ctrl
//
// Sequential radix-4 Booth multiplier controller: one signed 16x16 multiply
// per accepted start, retiring two multiplier bits per CALC cycle through a
// shared 18-bit adder. Eight CALC steps produce the signed 32-bit product.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-high reset (aborts any operation)
//   start         request, honoured only in IDLE or DONE
//   multiplicand  signed 16-bit M, captured on the accepted start
//   multiplier    signed 16-bit Q, captured on the accepted start
//   product       signed 32-bit M*Q, registered, held until the next result
//   busy          high while in CALC
//   done          one-cycle pulse while in DONE
//
// Build option:
//   R4BOOTH_ZERO_BYPASS_EN  when defined, a start with a zero operand goes
//                           straight to DONE with product 0 (latency 1).
// ---------------------------------------------------------------------------
module r4_booth_seq_ctrl (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [15:0] multiplicand,
  input  logic signed [15:0] multiplier,
  output logic signed [31:0] product,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic signed [17:0] acc;
  logic        [15:0] q;
  logic               qm1;
  logic signed [17:0] m18;
  logic        [2:0]  cnt;

  logic               accept;
  logic               bypass;
  logic               last_step;

  logic signed [17:0] addend;
  logic signed [17:0] sum;
  logic signed [17:0] acc_n;
  logic        [15:0] q_n;
  logic               qm1_n;

  // Booth digit selection: the 18-bit sign-extended M keeps 2M and -2M
  // representable even for M = -32768.
  function automatic logic signed [17:0] booth_addend(
    input logic        [2:0]  grp,
    input logic signed [17:0] m
  );
    logic signed [17:0] m2;
    m2 = m <<< 1;
    case (grp)
      3'b001, 3'b010: return m;
      3'b011:         return m2;
      3'b100:         return ~m2 + 18'sd1;
      3'b101, 3'b110: return ~m + 18'sd1;
      default:        return 18'sd0;
    endcase
  endfunction

  // One Booth step: add the digit, then arithmetic shift {S,Q,qm1} right by 2.
  always_comb begin
    addend = booth_addend({q[1], q[0], qm1}, m18);
    sum    = acc + addend;
    acc_n  = {sum[17], sum[17], sum[17:2]};
    q_n    = {sum[1:0], q[15:2]};
    qm1_n  = q[1];
  end

  // Control decode and next state
  always_comb begin
    state_n   = state;
    accept    = start && ((state == IDLE) || (state == DONE));
    last_step = (state == CALC) && (cnt == 3'd7);
    bypass    = 1'b0;
`ifdef R4BOOTH_ZERO_BYPASS_EN
    bypass    = accept && ((multiplicand == 16'sd0) || (multiplier == 16'sd0));
`endif
    case (state)
      IDLE, DONE: begin
        if (accept) state_n = bypass ? DONE : CALC;
        else        state_n = IDLE;
      end
      CALC: begin
        if (last_step) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register and registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n == CALC);
      done  <= (state_n == DONE);
    end
  end

  // Datapath registers; product only moves on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      q       <= '0;
      qm1     <= 1'b0;
      m18     <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      acc <= '0;
      q   <= multiplier;
      qm1 <= 1'b0;
      m18 <= {multiplicand[15], multiplicand[15], multiplicand};
      cnt <= '0;
      if (bypass) product <= '0;
    end else if (state == CALC) begin
      acc <= acc_n;
      q   <= q_n;
      qm1 <= qm1_n;
      cnt <= cnt + 3'd1;
      if (last_step) product <= {acc_n[15:0], q_n};
    end
  end

endmodule

// File: doc/r4_booth_seq_ctrl.md
# r4_booth_seq_ctrl

Sequential radix-4 Booth multiplication controller for the multiply/divide unit. It accepts one signed 16×16 operand pair per start pulse. It retires two multiplier bits per cycle by recoding them into one Booth digit and applying it to a shared 18-bit adder. It presents a registered signed 32-bit product with a done pulse. It is the multi-cycle, area-reduced counterpart to the combinational radix-4 Booth array and is driven by the same operand/product bus.

## Interface
- No parameters; widths are fixed at 16-bit operands and a 32-bit product.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the block is in IDLE or DONE.
- multiplicand  input  16  signed two's-complement M, captured on the accepted start.
- multiplier  input  16  signed two's-complement Q, captured on the accepted start.
- product  output  32  signed M×Q, registered, held until the next result.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse while in DONE.

## Operation
- Clock and reset are fixed: one clock, clk; reset rst is synchronous and active-high.
- State register: IDLE, CALC, DONE.
- Datapath registers:
  - A[17:0] accumulator.
  - Q[15:0] shift register.
  - qm1, the implicit Q[-1] bit.
  - M18 = sign-extended M.
  - cnt[2:0] iteration counter.
- Accepted start (in IDLE or DONE):
  - A=0, Q=multiplier, qm1=0, M18={M[15],M[15],M}, cnt=0.
  - Next state is CALC.
- CALC step: recode digit d from {Q[1],Q[0],qm1}:
  - 000/111 → 0.
  - 001/010 → +M.
  - 011 → +2M.
  - 100 → −2M.
  - 101/110 → −M.
- Each step computes S = A + d·M18 (18-bit, two's complement; 2M = M18<<1, −X via invert+1).
- Then {A,Q,qm1} ← arithmetic right shift of {S,Q,qm1} by 2, replicating S[17].
- cnt increments each step. After the step with cnt==7 (8 steps total), product ← {A[15:0],Q} as it results from that step, and next state is DONE.
- DONE lasts one cycle, then IDLE unless start is accepted.
- start in CALC is ignored, with no queuing.
- Arithmetic is exact for all inputs, including M=Q=−32768 (result 0x40000000). The 18-bit A guarantees no overflow.
- Reset at any time, including mid-CALC, aborts the operation. Reset values:
  - state=IDLE
  - busy=0, done=0
  - product=32'h0
  - A=0, Q=0, qm1=0, M18=0, cnt=0

## Timing
- Start accepted at edge E0.
- busy=1 during cycles E0..E8 (8 CALC cycles).
- done=1 and the new product are valid from E8 to E9 (latency 9 clocks, start edge to done).
- busy and done are never high together.
- product changes only at the edge entering DONE, or on reset.
- Back-to-back operation: start held high during DONE is accepted at E9, giving one result every 9 cycles. Neither busy nor done is asserted in the cycle after the accepting edge except as stated above.
- Simultaneous rst and start: rst wins.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- R4BOOTH_ZERO_BYPASS_EN, when defined:
  - An accepted start with multiplicand==0 or multiplier==0 skips CALC.
  - Next state is DONE directly, with product ← 0.
  - done is high from E0 to E1 (latency 1); busy stays 0.
- Not defined: zero operands take the full 8-step path (latency 9) and yield 0.

## Test plan
- Reset, then M=3, Q=−5 (0xFFFB) → product=0xFFFFFFF1 with done a single pulse exactly 9 cycles after the start edge; busy high for 8 cycles.
- Corners:
  - M=0x8000, Q=0x8000 → 0x40000000.
  - M=0x7FFF, Q=0x7FFF → 0x3FFF0001.
  - M=0x7FFF, Q=0x8000 → 0xC0008000.
- Back-to-back: start held high, pairs (100,200) then (−1,−1) → products 0x00004E20 then 0x00000001 on consecutive done pulses 9 cycles apart.
- start pulsed with new operands (9,9) mid-CALC of (2,3) → ignored; product=6, and the next done occurs only after a fresh start.
- rst asserted in the 4th CALC cycle → next cycle busy=0, done=0, product=0; a subsequent start (−7,6) gives 0xFFFFFFD6.
- Zero bypass: M=0, Q=0x1234:
  - With R4BOOTH_ZERO_BYPASS_EN: done 1 cycle after the start edge, busy never high, product=0.
  - Without it: done after 9 cycles, product=0.
